// File: rtl/signal_timestamper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : signal_timestamper                                              |
// | Brief    : Captures delay-compensated local time of an external event edge |
// |            into a one-entry buffer, read back over AXI4-Lite.              |
// | Option   : SIGNALTIMESTAMPER_CABLEDELAY_EN adds the CableDelay register.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module signal_timestamper #(
  parameter integer ClockPeriod_Gen   = 20,
  parameter integer InputDelay_Gen    = 0,
  parameter         InputPolarity_Gen = "true"
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRstN_RstIn,
  input  logic [31:0] ClockTime_Second_DatIn,
  input  logic [31:0] ClockTime_Nanosecond_DatIn,
  input  logic        ClockTime_TimeJump_DatIn,
  input  logic        ClockTime_ValIn,
  input  logic        SignalTimestamper_EvtIn,
  output logic        Irq_EvtOut,
  input  logic        AxiWriteAddrValid_ValIn,
  output logic        AxiWriteAddrReady_RdyOut,
  input  logic [15:0] AxiWriteAddrAddress_AdrIn,
  input  logic [2:0]  AxiWriteAddrProt_DatIn,
  input  logic        AxiWriteDataValid_ValIn,
  output logic        AxiWriteDataReady_RdyOut,
  input  logic [31:0] AxiWriteDataData_DatIn,
  input  logic [3:0]  AxiWriteDataStrobe_DatIn,
  output logic        AxiWriteRespValid_ValOut,
  input  logic        AxiWriteRespReady_RdyIn,
  output logic [1:0]  AxiWriteRespResponse_DatOut,
  input  logic        AxiReadAddrValid_ValIn,
  output logic        AxiReadAddrReady_RdyOut,
  input  logic [15:0] AxiReadAddrAddress_AdrIn,
  input  logic [2:0]  AxiReadAddrProt_DatIn,
  output logic        AxiReadDataValid_ValOut,
  input  logic        AxiReadDataReady_RdyIn,
  output logic [1:0]  AxiReadDataResponse_DatOut,
  output logic [31:0] AxiReadDataData_DatOut
);

`ifdef SIGNALTIMESTAMPER_CABLEDELAY_EN
  localparam logic c_cableDelayEn = 1'b1;
`else
  localparam logic c_cableDelayEn = 1'b0;
`endif

  localparam logic [31:0] c_version      = 32'h0001_0000;
  localparam logic [31:0] c_nsPerSec     = 32'd1_000_000_000;
  localparam logic [31:0] c_fixedDelay   = 32'(3 * ClockPeriod_Gen + InputDelay_Gen);
  localparam logic        c_polarityInit = (InputPolarity_Gen == "true") ? 1'b1 : 1'b0;
  localparam logic [1:0]  c_respOkay     = 2'b00;
  localparam logic [1:0]  c_respSlvErr   = 2'b10;

  localparam logic [2:0] c_addrControl = 3'd0;
  localparam logic [2:0] c_addrStatus  = 3'd1;
  localparam logic [2:0] c_addrPol     = 3'd2;
  localparam logic [2:0] c_addrVersion = 3'd3;
  localparam logic [2:0] c_addrCable   = 3'd4;
  localparam logic [2:0] c_addrCount   = 3'd5;
  localparam logic [2:0] c_addrTsNs    = 3'd6;
  localparam logic [2:0] c_addrTsSec   = 3'd7;

  logic        r_evtSync1, r_evtSync2, r_evtLast, r_edgeDet;
  logic        r_enable, r_irqEnable, r_polarity;
  logic [15:0] r_cableDelay;
  logic        r_dataValid, r_overflow, r_irq;
  logic [31:0] r_eventCount, r_tsNs, r_tsSec;
  logic        r_awReady, r_bValid, r_arReady, r_rValid;
  logic [1:0]  r_bResp, r_rResp;
  logic [31:0] r_rData;

  logic [2:0]  w_wrWord;
  logic        w_wrMapped, w_release, w_ovfClear;
  logic        w_capEdge, w_capture, w_overflowSet;
  logic [31:0] w_delay, w_nsDiff, w_capNs, w_capSec;
  logic        w_borrow;
  logic [31:0] w_rdData;
  logic [1:0]  w_rdResp;
  logic        w_unused;

  assign w_unused = &{1'b0, ClockTime_TimeJump_DatIn, AxiWriteAddrProt_DatIn, AxiReadAddrProt_DatIn,
                      AxiWriteAddrAddress_AdrIn[1:0], AxiReadAddrAddress_AdrIn[1:0],
                      AxiWriteDataData_DatIn[31:16], AxiWriteDataStrobe_DatIn[3:2]};

  // Sync1 samples at edge k, sync2 at k+1, edge flag at k+2, capture at k+3.
  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      r_evtSync1 <= 1'b0;
      r_evtSync2 <= 1'b0;
      r_evtLast  <= 1'b0;
      r_edgeDet  <= 1'b0;
    end else begin
      r_evtSync1 <= SignalTimestamper_EvtIn;
      r_evtSync2 <= r_evtSync1;
      r_evtLast  <= r_evtSync2;
      r_edgeDet  <= r_polarity ? (r_evtSync2 & ~r_evtLast) : (~r_evtSync2 & r_evtLast);
    end
  end

  assign w_delay  = c_fixedDelay + {16'd0, r_cableDelay};
  assign w_nsDiff = ClockTime_Nanosecond_DatIn - w_delay;
  assign w_borrow = (ClockTime_Nanosecond_DatIn < w_delay);
  assign w_capNs  = w_borrow ? (w_nsDiff + c_nsPerSec) : w_nsDiff;
  assign w_capSec = ClockTime_Second_DatIn - {31'd0, w_borrow};

  assign w_wrWord   = AxiWriteAddrAddress_AdrIn[4:2];
  assign w_wrMapped = (AxiWriteAddrAddress_AdrIn[15:5] == 11'd0) &&
                      ((w_wrWord != c_addrCable) || c_cableDelayEn);
  assign w_release  = r_awReady && w_wrMapped && (w_wrWord == c_addrStatus) &&
                      AxiWriteDataStrobe_DatIn[0] && AxiWriteDataData_DatIn[0];
  assign w_ovfClear = r_awReady && w_wrMapped && (w_wrWord == c_addrStatus) &&
                      AxiWriteDataStrobe_DatIn[0] && AxiWriteDataData_DatIn[1];

  // A release arriving on the capture edge frees the slot for the new event.
  assign w_capEdge     = r_edgeDet && r_enable && ClockTime_ValIn;
  assign w_capture     = w_capEdge && (!r_dataValid || w_release);
  assign w_overflowSet = w_capEdge && r_dataValid && !w_release;

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      r_enable     <= 1'b0;
      r_irqEnable  <= 1'b0;
      r_polarity   <= c_polarityInit;
      r_cableDelay <= 16'd0;
      r_dataValid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_eventCount <= 32'd0;
      r_tsNs       <= 32'd0;
      r_tsSec      <= 32'd0;
      r_irq        <= 1'b0;
    end else begin
      r_irq <= r_dataValid & r_irqEnable;
      if (r_awReady && w_wrMapped) begin
        case (w_wrWord)
          c_addrControl: if (AxiWriteDataStrobe_DatIn[0]) {r_irqEnable, r_enable} <= AxiWriteDataData_DatIn[1:0];
          c_addrPol:     if (AxiWriteDataStrobe_DatIn[0]) r_polarity <= AxiWriteDataData_DatIn[0];
          c_addrCable: begin
            if (AxiWriteDataStrobe_DatIn[0]) r_cableDelay[7:0]  <= AxiWriteDataData_DatIn[7:0];
            if (AxiWriteDataStrobe_DatIn[1]) r_cableDelay[15:8] <= AxiWriteDataData_DatIn[15:8];
          end
          default: ;
        endcase
      end
      if (w_capture) begin
        r_tsNs       <= w_capNs;
        r_tsSec      <= w_capSec;
        r_eventCount <= r_eventCount + 32'd1;
        r_dataValid  <= 1'b1;
      end else if (w_release) begin
        r_dataValid  <= 1'b0;
      end
      if (w_overflowSet) begin
        r_overflow <= 1'b1;
      end else if (w_ovfClear) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_comb begin
    w_rdData = 32'd0;
    w_rdResp = c_respOkay;
    if (AxiReadAddrAddress_AdrIn[15:5] != 11'd0) begin
      w_rdResp = c_respSlvErr;
    end else begin
      case (AxiReadAddrAddress_AdrIn[4:2])
        c_addrControl: w_rdData = {30'd0, r_irqEnable, r_enable};
        c_addrStatus:  w_rdData = {30'd0, r_overflow, r_dataValid};
        c_addrPol:     w_rdData = {31'd0, r_polarity};
        c_addrVersion: w_rdData = c_version;
        c_addrCable: begin
          if (c_cableDelayEn) w_rdData = {16'd0, r_cableDelay};
          else                w_rdResp = c_respSlvErr;
        end
        c_addrCount:   w_rdData = r_eventCount;
        c_addrTsNs:    w_rdData = r_tsNs;
        c_addrTsSec:   w_rdData = r_tsSec;
        default:       w_rdResp = c_respSlvErr;
      endcase
    end
  end

  always_ff @(posedge SysClk_ClkIn or negedge SysRstN_RstIn) begin
    if (!SysRstN_RstIn) begin
      r_awReady <= 1'b0;
      r_bValid  <= 1'b0;
      r_bResp   <= 2'b00;
      r_arReady <= 1'b0;
      r_rValid  <= 1'b0;
      r_rResp   <= 2'b00;
      r_rData   <= 32'd0;
    end else begin
      if (r_awReady) begin
        r_awReady <= 1'b0;
        r_bValid  <= 1'b1;
        r_bResp   <= w_wrMapped ? c_respOkay : c_respSlvErr;
      end else if (r_bValid && AxiWriteRespReady_RdyIn) begin
        r_bValid  <= 1'b0;
      end else if (AxiWriteAddrValid_ValIn && AxiWriteDataValid_ValIn && !r_bValid) begin
        r_awReady <= 1'b1;
      end

      if (r_arReady) begin
        r_arReady <= 1'b0;
        r_rValid  <= 1'b1;
        r_rData   <= w_rdData;
        r_rResp   <= w_rdResp;
      end else if (r_rValid && AxiReadDataReady_RdyIn) begin
        r_rValid  <= 1'b0;
      end else if (AxiReadAddrValid_ValIn && !r_rValid) begin
        r_arReady <= 1'b1;
      end
    end
  end

  assign Irq_EvtOut                  = r_irq;
  assign AxiWriteAddrReady_RdyOut    = r_awReady;
  assign AxiWriteDataReady_RdyOut    = r_awReady;
  assign AxiWriteRespValid_ValOut    = r_bValid;
  assign AxiWriteRespResponse_DatOut = r_bResp;
  assign AxiReadAddrReady_RdyOut     = r_arReady;
  assign AxiReadDataValid_ValOut     = r_rValid;
  assign AxiReadDataResponse_DatOut  = r_rResp;
  assign AxiReadDataData_DatOut      = r_rData;

endmodule
`default_nettype wire

// File: tb/tb_signal_timestamper.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_signal_timestamper                                           |
// | Brief    : Self-checking bench for signal_timestamper (event vectors + AXI)|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_signal_timestamper;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [31:0] sec = '0, ns = '0;
  logic        timeJump = 1'b0, valIn = 1'b0, evt = 1'b0;
  logic        irq;
  logic        awValid = 1'b0, awReady, wValid = 1'b0, wReady, bValid, bReady = 1'b0;
  logic [15:0] awAddr = '0, arAddr = '0;
  logic [31:0] wData = '0, rData;
  logic [3:0]  wStrb = '0;
  logic [1:0]  bResp, rResp;
  logic        arValid = 1'b0, arReady, rValid, rReady = 1'b0;

  always #5 clk = ~clk;

  signal_timestamper dut (
    .SysClk_ClkIn(clk), .SysRstN_RstIn(rstN),
    .ClockTime_Second_DatIn(sec), .ClockTime_Nanosecond_DatIn(ns),
    .ClockTime_TimeJump_DatIn(timeJump), .ClockTime_ValIn(valIn),
    .SignalTimestamper_EvtIn(evt), .Irq_EvtOut(irq),
    .AxiWriteAddrValid_ValIn(awValid), .AxiWriteAddrReady_RdyOut(awReady),
    .AxiWriteAddrAddress_AdrIn(awAddr), .AxiWriteAddrProt_DatIn(3'b000),
    .AxiWriteDataValid_ValIn(wValid), .AxiWriteDataReady_RdyOut(wReady),
    .AxiWriteDataData_DatIn(wData), .AxiWriteDataStrobe_DatIn(wStrb),
    .AxiWriteRespValid_ValOut(bValid), .AxiWriteRespReady_RdyIn(bReady),
    .AxiWriteRespResponse_DatOut(bResp),
    .AxiReadAddrValid_ValIn(arValid), .AxiReadAddrReady_RdyOut(arReady),
    .AxiReadAddrAddress_AdrIn(arAddr), .AxiReadAddrProt_DatIn(3'b000),
    .AxiReadDataValid_ValOut(rValid), .AxiReadDataReady_RdyIn(rReady),
    .AxiReadDataResponse_DatOut(rResp), .AxiReadDataData_DatOut(rData)
  );

  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10;

  typedef struct { logic [31:0] data; logic [1:0] resp; } rdExp_t;
  typedef struct {
    logic [31:0] sec, ns;
    logic        pol, rising, valid, expCap;
    logic [31:0] expSec, expNs;
  } vec_t;

  rdExp_t     rdQ[$];
  string      rdNameQ[$];
  logic [1:0] wrQ[$];
  vec_t       vecs[7];
  int         total = 0, bad = 0;
  logic [31:0] expCount = 0, expSec = 0, expNs = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axiRead(input logic [15:0] addr, input logic [31:0] expData,
                         input logic [1:0] expResp, input string name);
    rdExp_t e;
    string  nm;
    int     n;
    e.data = expData;
    e.resp = expResp;
    rdQ.push_back(e);
    rdNameQ.push_back(name);
    arAddr  = addr;
    arValid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!arReady && n < 20);
    check({name, "_arready"}, 32'(arReady), 32'd1);
    @(negedge clk);
    arValid = 1'b0;
    n = 0;
    while (!rValid && n < 20) begin @(negedge clk); n++; end
    check({name, "_rvalid"}, 32'(rValid), 32'd1);
    e  = rdQ.pop_front();
    nm = rdNameQ.pop_front();
    check(nm, rData, e.data);
    check({nm, "_resp"}, 32'(rResp), 32'(e.resp));
    rReady = 1'b1;
    @(negedge clk);
    rReady = 1'b0;
  endtask

  task automatic axiWrite(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] expResp, input int holdB, input string name);
    int n;
    wrQ.push_back(expResp);
    awAddr  = addr;
    wData   = data;
    wStrb   = strb;
    awValid = 1'b1;
    wValid  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!awReady && n < 20);
    check({name, "_ready"}, 32'({awReady, wReady}), 32'd3);
    @(negedge clk);
    awValid = 1'b0;
    wValid  = 1'b0;
    n = 0;
    while (!bValid && n < 20) begin @(negedge clk); n++; end
    check({name, "_bvalid"}, 32'(bValid), 32'd1);
    for (int i = 0; i < holdB; i++) begin
      @(negedge clk);
      check({name, "_bhold"}, 32'(bValid), 32'd1);
    end
    check({name, "_bresp"}, 32'(bResp), 32'(wrQ.pop_front()));
    bReady = 1'b1;
    @(negedge clk);
    bReady = 1'b0;
    if (holdB > 0) check({name, "_bdrop"}, 32'(bValid), 32'd0);
  endtask

  task automatic driveEvt(input logic level);
    evt = level;
    repeat (8) @(negedge clk);
  endtask

  task automatic checkBuffer(input string name, input logic [31:0] status);
    axiRead(16'h04, status, OKAY, {name, "_status"});
    axiRead(16'h14, expCount, OKAY, {name, "_count"});
    axiRead(16'h18, expNs, OKAY, {name, "_tsNs"});
    axiRead(16'h1C, expSec, OKAY, {name, "_tsSec"});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        sec          ns            pol   rise  val   cap   expSec  expNs
    vecs[0] = '{32'd7,  32'd1000,      1'b1, 1'b1, 1'b1, 1'b1, 32'd7,  32'd940};
    vecs[1] = '{32'd5,  32'd30,        1'b1, 1'b1, 1'b1, 1'b1, 32'd4,  32'd999999970};
    vecs[2] = '{32'd9,  32'd500,       1'b1, 1'b1, 1'b0, 1'b0, 32'd0,  32'd0};
    vecs[3] = '{32'd9,  32'd500,       1'b1, 1'b0, 1'b1, 1'b0, 32'd0,  32'd0};
    vecs[4] = '{32'd11, 32'd60,        1'b0, 1'b0, 1'b1, 1'b1, 32'd11, 32'd0};
    vecs[5] = '{32'd3,  32'd59,        1'b0, 1'b0, 1'b1, 1'b1, 32'd2,  32'd999999999};
    vecs[6] = '{32'd0,  32'd999999999, 1'b1, 1'b1, 1'b1, 1'b1, 32'd0,  32'd999999939};

    repeat (3) @(negedge clk);
    check("rst_handshake", 32'({awReady, wReady, bValid, arReady, rValid}), 32'd0);
    rstN = 1'b1;
    @(negedge clk);
    check("reset_outputs", 32'({awReady, wReady, bValid, arReady, rValid, irq}), 32'd0);
    check("reset_resp_data", {rData[29:0], bResp} | 32'(rResp), 32'd0);

    axiRead(16'h00, 32'd0, OKAY, "reset_control");
    axiRead(16'h08, 32'd1, OKAY, "reset_polarity");
    checkBuffer("reset", 32'd0);

    axiWrite(16'h00, 32'd3, 4'hF, OKAY, 0, "enable");
    valIn = 1'b1;

    foreach (vecs[i]) begin
      axiWrite(16'h04, 32'd3, 4'hF, OKAY, 0, "release");
      axiWrite(16'h08, 32'(vecs[i].pol), 4'hF, OKAY, 0, "polarity");
      valIn = 1'b0;
      driveEvt(~vecs[i].rising);
      sec   = vecs[i].sec;
      ns    = vecs[i].ns;
      valIn = vecs[i].valid;
      driveEvt(vecs[i].rising);
      valIn = 1'b1;
      if (vecs[i].expCap) begin
        expCount++;
        expSec = vecs[i].expSec;
        expNs  = vecs[i].expNs;
      end
      check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].expCap));
      checkBuffer($sformatf("vec%0d", i), 32'(vecs[i].expCap));
    end

    // Second active edge while the buffer is full.
    driveEvt(1'b0);
    sec = 32'd20;
    ns  = 32'd777;
    driveEvt(1'b1);
    check("ovf_irq", 32'(irq), 32'd1);
    checkBuffer("overflow", 32'd3);
    axiWrite(16'h04, 32'd3, 4'hF, OKAY, 0, "ovf_clear");
    axiRead(16'h04, 32'd0, OKAY, "ovf_cleared");
    check("ovf_irq_low", 32'(irq), 32'd0);

    // Release write landing exactly on the capture edge.
    driveEvt(1'b0);
    sec = 32'd30;
    ns  = 32'd5000;
    driveEvt(1'b1);
    expCount++;
    expSec = 32'd30;
    expNs  = 32'd4940;
    checkBuffer("pre_simul", 32'd1);
    driveEvt(1'b0);
    sec = 32'd31;
    ns  = 32'd100;
    @(negedge clk);
    evt = 1'b1;
    @(negedge clk);
    @(negedge clk);
    axiWrite(16'h04, 32'd1, 4'hF, OKAY, 0, "simul_release");
    repeat (4) @(negedge clk);
    expCount++;
    expSec = 32'd31;
    expNs  = 32'd40;
    checkBuffer("simul", 32'd1);
    axiWrite(16'h04, 32'd1, 4'hF, OKAY, 0, "release2");

    // Disabled: edge dropped, buffer retained.
    axiWrite(16'h00, 32'd2, 4'hF, OKAY, 0, "disable");
    driveEvt(1'b0);
    sec = 32'd40;
    driveEvt(1'b1);
    checkBuffer("disabled", 32'd0);
    axiWrite(16'h00, 32'd3, 4'hF, OKAY, 0, "reenable");

    axiRead(16'h0C, 32'h0001_0000, OKAY, "version");
    axiRead(16'h40, 32'd0, SLVERR, "unmapped_rd");
    axiWrite(16'h40, 32'hFFFF_FFFF, 4'hF, SLVERR, 0, "unmapped_wr");
    axiWrite(16'h00, 32'd0, 4'hE, OKAY, 0, "strb_upper");
    axiRead(16'h00, 32'd3, OKAY, "strb_upper_ctrl");
    axiWrite(16'h00, 32'd1, 4'h1, OKAY, 0, "strb_byte0");
    axiRead(16'h00, 32'd1, OKAY, "strb_byte0_ctrl");
    axiWrite(16'h00, 32'd3, 4'h1, OKAY, 5, "bready_hold");

`ifdef SIGNALTIMESTAMPER_CABLEDELAY_EN
    axiWrite(16'h10, 32'd100, 4'hF, OKAY, 0, "cable_wr");
    axiRead(16'h10, 32'd100, OKAY, "cable_rd");
    driveEvt(1'b0);
    sec = 32'd7;
    ns  = 32'd1000;
    driveEvt(1'b1);
    expCount++;
    expSec = 32'd7;
    expNs  = 32'd840;
    checkBuffer("cable", 32'd1);
`else
    axiRead(16'h10, 32'd0, SLVERR, "cable_rd");
    axiWrite(16'h10, 32'd100, 4'hF, SLVERR, 0, "cable_wr");
`endif

    // Reset during an in-flight read aborts the handshake immediately.
    arAddr  = 16'h0C;
    arValid = 1'b1;
    for (int n = 0; n < 20 && !arReady; n++) @(negedge clk);
    check("midrst_arready_pre", 32'(arReady), 32'd1);
    rstN = 1'b0;
    #1;
    check("midrst_abort", 32'({arReady, rValid, awReady, bValid, irq}), 32'd0);
    arValid = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    expCount = 0;
    expSec   = 0;
    expNs    = 0;
    checkBuffer("post_rst", 32'd0);
    axiRead(16'h00, 32'd0, OKAY, "post_rst_control");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
